// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the MuxUnit select sequencer and its datapath.
package mux_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int         STEPS     = 4;
  localparam logic [1:0] LAST_STEP = 2'd3;

  // Fixed lane constants: lane 0 offers 1..3, lane 1 offers 4..6.
  localparam logic [7:0] L0_C1 = 8'd1;
  localparam logic [7:0] L0_C2 = 8'd2;
  localparam logic [7:0] L0_C3 = 8'd3;
  localparam logic [7:0] L1_C4 = 8'd4;
  localparam logic [7:0] L1_C5 = 8'd5;
  localparam logic [7:0] L1_C6 = 8'd6;
endpackage

// File: rtl/mux_unit_sequencer_muxunit.sv
// MuxUnit datapath: two combinational 4:1 byte muxes, each picking its operand or a lane constant.
module MuxUnit
  import mux_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] op_0,
  input  logic [WIDTH-1:0] op_1,
  input  logic [1:0]       sel_0,
  input  logic [1:0]       sel_1,
  output logic [WIDTH-1:0] out_0,
  output logic [WIDTH-1:0] out_1
);
  always_comb begin
    case (sel_0)
      2'd0:    out_0 = op_0;
      2'd1:    out_0 = WIDTH'(L0_C1);
      2'd2:    out_0 = WIDTH'(L0_C2);
      default: out_0 = WIDTH'(L0_C3);
    endcase
  end

  // Lane 1 is wired so that a descending select walks 6, 5, 4, then the operand.
  always_comb begin
    case (sel_1)
      2'd0:    out_1 = op_1;
      2'd1:    out_1 = WIDTH'(L1_C4);
      2'd2:    out_1 = WIDTH'(L1_C5);
      default: out_1 = WIDTH'(L1_C6);
    endcase
  end
endmodule

// File: rtl/mux_unit_sequencer.sv
// Sweeps MuxUnit through four select steps, folding both lanes into a sum and a max,
// then offers the result on a valid/ready handshake.
module mux_unit_sequencer
  import mux_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = WIDTH + 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_0,
  input  logic [WIDTH-1:0] op_1,
  output logic             busy,
  output logic [1:0]       sel_0,
  output logic [1:0]       sel_1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_sum,
  output logic [WIDTH-1:0] res_max
);
  state_t           r_state, w_next;
  logic [1:0]       r_step;
  logic [WIDTH-1:0] r_op_0, r_op_1;
  logic [ACC_W-1:0] r_acc;
  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] w_out_0, w_out_1, w_lane_max, w_new_max;

  MuxUnit #(.WIDTH(WIDTH)) u_mux (
    .op_0  (r_op_0),
    .op_1  (r_op_1),
    .sel_0 (sel_0),
    .sel_1 (sel_1),
    .out_0 (w_out_0),
    .out_1 (w_out_1)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_step == LAST_STEP) w_next = DONE;
      DONE:    if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != IDLE);
    res_valid = (r_state == DONE);
    sel_0     = 2'd0;
    sel_1     = 2'd0;
    if (r_state == RUN) begin
      sel_0 = r_step;
      sel_1 = ~r_step;
    end
  end

  always_comb begin
    w_lane_max = (w_out_0 > w_out_1) ? w_out_0 : w_out_1;
    w_new_max  = (w_lane_max > r_max) ? w_lane_max : r_max;
  end

  // Accumulators double as the registered result; they only move in RUN, so DONE holds them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step <= 2'd0;
      r_op_0 <= '0;
      r_op_1 <= '0;
      r_acc  <= '0;
      r_max  <= '0;
    end else if (r_state == IDLE && start) begin
      r_step <= 2'd0;
      r_op_0 <= op_0;
      r_op_1 <= op_1;
      r_acc  <= '0;
      r_max  <= '0;
    end else if (r_state == RUN) begin
      r_step <= r_step + 2'd1;
      r_acc  <= r_acc + ACC_W'(w_out_0) + ACC_W'(w_out_1);
      r_max  <= w_new_max;
    end
  end

  assign res_sum = r_acc;
  assign res_max = r_max;
endmodule

// File: tb/tb_mux_unit_sequencer.sv
// Randomized self-checking bench for mux_unit_sequencer against a sum/max reference model.
module tb_mux_unit_sequencer;
  import mux_seq_pkg::*;
  localparam int WIDTH = 8;
  localparam int ACC_W = WIDTH + 3;

  logic             clk = 1'b0;
  logic             rst, start, res_ready;
  logic [WIDTH-1:0] op_0, op_1;
  logic             busy, res_valid;
  logic [1:0]       sel_0, sel_1;
  logic [ACC_W-1:0] res_sum;
  logic [WIDTH-1:0] res_max;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_unit_sequencer #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_0(op_0), .op_1(op_1),
    .busy(busy), .sel_0(sel_0), .sel_1(sel_1), .res_valid(res_valid),
    .res_ready(res_ready), .res_sum(res_sum), .res_max(res_max)
  );

  // Reference: every sweep sees op_0, op_1 and the six lane constants exactly once.
  function automatic logic [ACC_W-1:0] ref_sum(input int a, input int b);
    return ACC_W'(a + b + 1 + 2 + 3 + 4 + 5 + 6);
  endfunction

  function automatic logic [WIDTH-1:0] ref_max(input int a, input int b);
    int m;
    m = 6;
    if (a > m) m = a;
    if (b > m) m = b;
    return WIDTH'(m);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; res_ready = 1'b0; op_0 = '0; op_1 = '0;
    tick(); tick();
    n_checks++;
    if ({busy, res_valid, sel_0, sel_1, res_sum, res_max} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b valid=%b sel0=%0d sel1=%0d sum=%h max=%h, want all 0",
               busy, res_valid, sel_0, sel_1, res_sum, res_max);
    end
    rst = 1'b0;
    tick();
  endtask

  // Full sweep with ready high: checks select sequence, latency, result and return to idle.
  task automatic test_sweep(input string tag, input int a, input int b);
    op_0 = WIDTH'(a); op_1 = WIDTH'(b); start = 1'b1; res_ready = 1'b1;
    tick();
    start = 1'b0;
    op_0 = WIDTH'($urandom);
    op_1 = WIDTH'($urandom);
    for (int k = 0; k < STEPS; k++) begin
      n_checks++;
      if (sel_0 !== 2'(k) || sel_1 !== 2'(3 - k) || res_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_step%0d: got sel0=%0d sel1=%0d valid=%b busy=%b, want sel0=%0d sel1=%0d valid=0 busy=1",
                 tag, k, sel_0, sel_1, res_valid, busy, k, 3 - k);
      end
      tick();
    end
    n_checks++;
    if (res_valid !== 1'b1 || res_sum !== ref_sum(a, b) || res_max !== ref_max(a, b) ||
        sel_0 !== 2'd0 || sel_1 !== 2'd0) begin
      n_fail++;
      $display("FAIL %s_result: got valid=%b sum=%h max=%h sel0=%0d sel1=%0d, want valid=1 sum=%h max=%h sels 0",
               tag, res_valid, res_sum, res_max, sel_0, sel_1, ref_sum(a, b), ref_max(a, b));
    end
    tick();
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: got valid=%b busy=%b, want 0 0", tag, res_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    int a, b, waited;
    a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255));
    op_0 = WIDTH'(a); op_1 = WIDTH'(b); start = 1'b1; res_ready = 1'b0;
    tick();
    start = 1'b0;
    waited = 0;
    while (res_valid !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_wait_valid: got valid=%b after %0d cycles, want 1", res_valid, waited);
    end
    for (int c = 0; c < 3; c++) begin
      start = 1'b1;
      op_0 = WIDTH'($urandom);
      tick();
      n_checks++;
      if (res_valid !== 1'b1 || busy !== 1'b1 || res_sum !== ref_sum(a, b) || res_max !== ref_max(a, b)) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got valid=%b busy=%b sum=%h max=%h, want 1 1 %h %h",
                 c, res_valid, busy, res_sum, res_max, ref_sum(a, b), ref_max(a, b));
      end
    end
    start = 1'b0;
    res_ready = 1'b1;
    tick();
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_transfer: got valid=%b busy=%b, want 0 0", res_valid, busy);
    end
    tick();
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_queued_start: got valid=%b busy=%b, want 0 0", res_valid, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    op_0 = 8'h55; op_1 = 8'hAA; start = 1'b1; res_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({busy, res_valid, sel_0, sel_1, res_sum, res_max} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: got busy=%b valid=%b sel0=%0d sel1=%0d sum=%h max=%h, want all 0",
               busy, res_valid, sel_0, sel_1, res_sum, res_max);
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midrun_discarded%0d: got valid=%b busy=%b, want 0 0", c, res_valid, busy);
      end
    end
    test_sweep("after_reset", 1, 2);
  endtask

  // start held high: one acceptance every 6 edges; ops latched are the ones present at those edges.
  task automatic test_back_to_back();
    int ra[18], rb[18];
    res_ready = 1'b1;
    start = 1'b1;
    for (int t = 0; t < 18; t++) begin
      ra[t] = int'($urandom_range(0, 255));
      rb[t] = int'($urandom_range(0, 255));
      op_0 = WIDTH'(ra[t]); op_1 = WIDTH'(rb[t]);
      tick();
      n_checks++;
      if (t % 6 == 4) begin
        if (res_valid !== 1'b1 || res_sum !== ref_sum(ra[t-4], rb[t-4]) || res_max !== ref_max(ra[t-4], rb[t-4])) begin
          n_fail++;
          $display("FAIL b2b_result_t%0d: got valid=%b sum=%h max=%h, want 1 %h %h",
                   t, res_valid, res_sum, res_max, ref_sum(ra[t-4], rb[t-4]), ref_max(ra[t-4], rb[t-4]));
        end
      end else begin
        if (res_valid !== 1'b0 || busy !== (t % 6 != 5)) begin
          n_fail++;
          $display("FAIL b2b_state_t%0d: got valid=%b busy=%b, want 0 %b", t, res_valid, busy, t % 6 != 5);
        end
      end
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      test_sweep("random", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
  endtask

  initial begin
    test_reset();
    test_sweep("basic", 8'h10, 8'h20);
    test_sweep("zeros", 8'h00, 8'h00);
    test_sweep("ones", 8'hFF, 8'hFF);
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
